// File: rtl/stream_packer_pkg.sv
// Shared types and constants for the stream packer.
//  state_t       : packet FSM state (idle / header beat / payload beat)
//  HDR_W, TID_W  : header and stream-ID widths that make up the 19-bit address
//  SLEEP_TID_DEF : default stream ID that is parked while its destination sleeps
//  pack_addr()   : builds the {hdr, tid} source address
package stream_packer_pkg;
  localparam int HDR_W  = 16;
  localparam int TID_W  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = HDR_W + TID_W;
  localparam int PKT_W  = HDR_W + DATA_W;

  localparam logic [TID_W-1:0] SLEEP_TID_DEF = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PLD  = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [HDR_W-1:0] hdr,
                                                 input logic [TID_W-1:0] tid);
    return {hdr, tid};
  endfunction
endpackage

// File: rtl/qs_fifo.sv
// Parking FIFO for sleeping-destination transactions.
//  push_i/din_i : write an entry (ignored when full)
//  pop_i/dout_o : dout_o shows the head entry; pop_i removes it (ignored when empty)
//  full_o/empty_o : occupancy flags
// Push and pop in the same cycle leave the count unchanged.
module qs_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/stream_packer.sv
// Turns single-cycle addr+data transactions into 2-beat stream packets
// (header beat, then payload beat with tlast). Transactions for SLEEP_TID are
// parked in a FIFO while that destination sleeps and drained once it wakes.
//  src_*  : valid/ready transaction input, addr = {hdr[15:0], tid[2:0]}
//  rsp_*  : registered stream output (tvalid/tid/tdata/tlast, tready backpressure)
//  dst_opmode_i : 1 = SLEEP_TID destination awake
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int               DEPTH     = 8,
  parameter logic [TID_W-1:0] SLEEP_TID = SLEEP_TID_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              src_ready_o,
  output logic              rsp_tvalid_o,
  output logic [TID_W-1:0]  rsp_tid_o,
  output logic [DATA_W-1:0] rsp_tdata_o,
  output logic              rsp_tlast_o,
  input  logic              rsp_tready_i,
  input  logic              dst_opmode_i
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [TID_W-1:0]  tid_q, tid_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              drain_q, drain_d;

  logic [TID_W-1:0]  src_tid;
  logic [HDR_W-1:0]  src_hdr;
  logic              is_idle, park, push, pop, drain, accept_direct;
  logic              fifo_full, fifo_empty;
  logic [PKT_W-1:0]  fifo_dout;

  assign src_tid = src_addr_i[TID_W-1:0];
  assign src_hdr = src_addr_i[ADDR_W-1:TID_W];
  assign is_idle = (state_q == ST_IDLE);

  assign park  = src_valid_i & (src_tid == SLEEP_TID) & ~dst_opmode_i;
  // Once a drain starts it runs to empty even if the destination falls asleep again.
  assign drain = (is_idle & ~fifo_empty & dst_opmode_i) | (drain_q & ~fifo_empty);
  assign push  = park & ~fifo_full;
  assign pop   = is_idle & drain;

  // Parked traffic only needs FIFO space; direct traffic needs an idle FSM with no drain pending.
  assign src_ready_o   = park ? ~fifo_full : (is_idle & ~drain);
  assign accept_direct = src_valid_i & ~park & is_idle & ~drain;

  qs_fifo #(.DEPTH(DEPTH), .DATA_W(PKT_W)) u_park_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({src_hdr, src_data_i}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    drain_d  = drain;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tdata_d  = fifo_dout[PKT_W-1 -: HDR_W];
          data_d   = fifo_dout[DATA_W-1:0];
          tid_d    = SLEEP_TID;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = ST_HDR;
        end else if (accept_direct) begin
          tdata_d  = src_hdr;
          data_d   = src_data_i;
          tid_d    = src_tid;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (rsp_tready_i) begin
          tdata_d = data_q;
          tlast_d = 1'b1;
          state_d = ST_PLD;
        end
      end
      ST_PLD: begin
        if (rsp_tready_i) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      drain_q  <= drain_d;
    end
  end

  assign rsp_tvalid_o = tvalid_q;
  assign rsp_tid_o    = tid_q;
  assign rsp_tdata_o  = tdata_q;
  assign rsp_tlast_o  = tlast_q;
endmodule

// File: tb/tb_stream_packer.sv
module tb_stream_packer;
  import stream_packer_pkg::*;

  localparam int DEPTH = 8;
  localparam int WAIT_LIMIT = 300;

  typedef struct {
    logic [2:0]  tid;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk, reset;
  logic        src_valid, src_ready;
  logic [18:0] src_addr;
  logic [15:0] src_data;
  logic        tvalid, tlast, tready, opmode;
  logic [2:0]  tid;
  logic [15:0] tdata;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  stream_packer #(.DEPTH(DEPTH), .SLEEP_TID(3'd5)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid_i  (src_valid),
    .src_addr_i   (src_addr),
    .src_data_i   (src_data),
    .src_ready_o  (src_ready),
    .rsp_tvalid_o (tvalid),
    .rsp_tid_o    (tid),
    .rsp_tdata_o  (tdata),
    .rsp_tlast_o  (tlast),
    .rsp_tready_i (tready),
    .dst_opmode_i (opmode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_pkt(input logic [2:0] t, input logic [15:0] h, input logic [15:0] d);
    sb.push_back('{t, h, 1'b0});
    sb.push_back('{t, d, 1'b1});
  endtask

  // Called at posedge+1; leaves valid asserted.
  task automatic drive(input logic [15:0] h, input logic [2:0] t, input logic [15:0] d);
    src_valid = 1'b1;
    src_addr  = pack_addr(h, t);
    src_data  = d;
  endtask

  // Waits (bounded) for ready, lets the handshake edge pass, returns at posedge+1.
  task automatic wait_acc(input string tag);
    int n = 0;
    @(negedge clk);
    while (!src_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(tag, src_ready, 1'b1);
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  // Scoreboard monitor: every completed beat must match the head of the queue.
  always @(negedge clk) begin
    if (tvalid && tready) begin
      chk("beat_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_tid", tid, e.tid);
        chk("beat_data", tdata, e.data);
        chk("beat_last", tlast, e.last);
      end
    end
  end

  initial begin
    clk = 0; reset = 1; src_valid = 0; src_addr = '0; src_data = '0;
    tready = 1; opmode = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tid", tid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_ready", src_ready, 1);
    @(posedge clk); #1 reset = 0;

    // 1: direct packet, latency N+1 / N+2
    exp_pkt(3'd2, 16'hABCD, 16'h1234);
    drive(16'hABCD, 3'd2, 16'h1234);
    wait_acc("t1_accept");
    @(negedge clk);
    chk("t1_hdr_valid", tvalid, 1);
    chk("t1_hdr_data", tdata, 16'hABCD);
    chk("t1_hdr_last", tlast, 0);
    @(negedge clk);
    chk("t1_pld_data", tdata, 16'h1234);
    chk("t1_pld_last", tlast, 1);
    @(negedge clk);
    chk("t1_idle_tvalid", tvalid, 0);
    @(posedge clk); #1;

    // 2: backpressure in header beat
    tready = 0;
    exp_pkt(3'd2, 16'hABCD, 16'h5678);
    drive(16'hABCD, 3'd2, 16'h5678);
    wait_acc("t2_accept");
    repeat (4) begin
      @(negedge clk);
      chk("t2_hold_valid", tvalid, 1);
      chk("t2_hold_data", tdata, 16'hABCD);
      chk("t2_hold_tid", tid, 3'd2);
      chk("t2_ready_low", src_ready, 0);
    end
    @(posedge clk); #1 tready = 1;
    repeat (4) @(posedge clk); #1;
    chk("t2_sb_empty", sb.size(), 0);

    // 3: park three, then wake
    opmode = 0;
    for (int i = 1; i <= 3; i++) begin
      drive(16'h3000 + 16'(i), 3'd5, 16'(i));
      wait_acc("t3_park_accept");
    end
    repeat (3) begin
      @(negedge clk);
      chk("t3_no_tvalid", tvalid, 0);
    end
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) exp_pkt(3'd5, 16'h3000 + 16'(i), 16'(i));
    opmode = 1;
    repeat (15) @(posedge clk); #1;
    chk("t3_drained", sb.size(), 0);

    // 4: fill FIFO, 9th refused until drain completes
    opmode = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(16'h4000 + 16'(i), 3'd5, 16'h0040 + 16'(i));
      wait_acc("t4_park_accept");
    end
    drive(16'h4008, 3'd5, 16'h0048);
    @(negedge clk);
    chk("t4_full_ready", src_ready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) exp_pkt(3'd5, 16'h4000 + 16'(i), 16'h0040 + 16'(i));
    exp_pkt(3'd5, 16'h4008, 16'h0048);
    opmode = 1;
    wait_acc("t4_ninth_accept");
    repeat (6) @(posedge clk); #1;
    chk("t4_drained", sb.size(), 0);

    // 5: sticky drain beats a waiting direct txn
    opmode = 0;
    for (int i = 0; i < 4; i++) begin
      drive(16'h5000 + 16'(i), 3'd5, 16'h0050 + 16'(i));
      wait_acc("t5_park_accept");
    end
    for (int i = 0; i < 4; i++) exp_pkt(3'd5, 16'h5000 + 16'(i), 16'h0050 + 16'(i));
    exp_pkt(3'd1, 16'h1111, 16'h0001);
    opmode = 1;
    @(posedge clk); #1;
    opmode = 0;
    drive(16'h1111, 3'd1, 16'h0001);
    wait_acc("t5_direct_accept");
    repeat (6) @(posedge clk); #1;
    chk("t5_drained", sb.size(), 0);

    // 6: reset in payload beat with two parked
    for (int i = 0; i < 2; i++) begin
      drive(16'h6000 + 16'(i), 3'd5, 16'h0060 + 16'(i));
      wait_acc("t6_park_accept");
    end
    sb.push_back('{3'd3, 16'h6666, 1'b0});
    drive(16'h6666, 3'd3, 16'h7777);
    wait_acc("t6_direct_accept");
    @(posedge clk); #1 tready = 0;
    @(negedge clk);
    chk("t6_in_pld", tlast, 1);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("t6_rst_tvalid", tvalid, 0);
    chk("t6_rst_tlast", tlast, 0);
    chk("t6_rst_ready", src_ready, 1);
    @(posedge clk); #1;
    reset = 0; opmode = 1; tready = 1;
    repeat (10) begin
      @(negedge clk);
      chk("t6_no_pkt", tvalid, 0);
    end
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
